// File: rtl/master1_ctrl.sv
// rtl/master1_ctrl.sv - serial frame master with acknowledge, timeout and retry
//
// Sends one frame per accepted request, then waits for the slave's acknowledge.
// Frame on tx, one bit per clock: start 0, SLAVE_ADDR MSB first, data register
// MSB first, stop 1. After an acknowledge the data register increments; after
// MAX_RETRY unanswered retransmissions the frame is dropped.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rstn       - asynchronous active-low reset
//   data_ready - transaction request, sampled only in IDLE
//   rx         - serial line from slave, idle high, low = acknowledge
//   tx         - registered serial line to slave, idle high
module master1_ctrl #(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR  = 4'h1,
    parameter logic [DATA_WIDTH-1:0] DATA_INIT   = 8'h00,
    parameter int                    ACK_TIMEOUT = 16,
    parameter int                    MAX_RETRY   = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic data_ready,
    input  logic rx,
    output logic tx
);

    localparam int FRAME_LEN = ADDR_WIDTH + DATA_WIDTH + 2;
    localparam int BC_W      = $clog2(FRAME_LEN + 1);
    localparam int TO_W      = $clog2(ACK_TIMEOUT + 1);
    localparam int RT_W      = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        DONE
    } state_t;

    state_t                  state, state_n;
    logic                    tx_n;
    logic [FRAME_LEN-1:0]    shift, shift_n;
    logic [BC_W-1:0]         bit_cnt, bit_cnt_n;
    logic [TO_W-1:0]         to_cnt, to_cnt_n;
    logic [RT_W-1:0]         retry, retry_n;
    logic [DATA_WIDTH-1:0]   data_reg, data_n;
    logic [FRAME_LEN-1:0]    frame;

    assign frame = {1'b0, SLAVE_ADDR, data_reg, 1'b1};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= '1;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            retry    <= '0;
            data_reg <= DATA_INIT;
        end else begin
            state    <= state_n;
            tx       <= tx_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            to_cnt   <= to_cnt_n;
            retry    <= retry_n;
            data_reg <= data_n;
        end
    end

    always_comb begin
        state_n   = state;
        tx_n      = 1'b1;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        to_cnt_n  = to_cnt;
        retry_n   = retry;
        data_n    = data_reg;

        case (state)
            IDLE: begin
                if (data_ready) begin
                    // Start bit goes out on the accepting edge itself, so the
                    // shifter is loaded with the remaining bits only.
                    tx_n      = frame[FRAME_LEN-1];
                    shift_n   = {frame[FRAME_LEN-2:0], 1'b1};
                    bit_cnt_n = BC_W'(1);
                    retry_n   = '0;
                    state_n   = SEND;
                end
            end

            SEND: begin
                if (bit_cnt == BC_W'(FRAME_LEN)) begin
                    // Stop bit has been on the line for a full cycle.
                    to_cnt_n = '0;
                    state_n  = WAIT_ACK;
                end else begin
                    tx_n      = shift[FRAME_LEN-1];
                    shift_n   = {shift[FRAME_LEN-2:0], 1'b1};
                    bit_cnt_n = bit_cnt + BC_W'(1);
                end
            end

            WAIT_ACK: begin
                if (!rx) begin
                    state_n = DONE;
                end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    if (retry < RT_W'(MAX_RETRY)) begin
                        // Re-enter SEND at bit 0 so the start bit is driven
                        // on the following edge, not this one.
                        retry_n   = retry + RT_W'(1);
                        shift_n   = frame;
                        bit_cnt_n = '0;
                        state_n   = SEND;
                    end else begin
                        retry_n = '0;
                        state_n = IDLE;
                    end
                end else begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end

            DONE: begin
                data_n  = data_reg + DATA_WIDTH'(1);
                retry_n = '0;
                state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_master1_ctrl.sv
// tb/tb_master1_ctrl.sv - directed self-checking bench for master1_ctrl
module tb_master1_ctrl;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic data_ready = 1'b0;
    logic rx = 1'b1;
    logic tx;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_data = 8'h00;

    master1_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .data_ready (data_ready),
        .rx         (rx),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] exp_frame(input logic [7:0] d);
        return {1'b0, 4'h1, d, 1'b1};
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the negedge after the stop bit.
    task automatic do_frame(output logic [13:0] bits);
        data_ready = 1'b1;
        @(negedge clk);
        bits[13] = tx;
        data_ready = 1'b0;
        for (int i = 12; i >= 0; i--) begin
            @(negedge clk);
            bits[i] = tx;
        end
    endtask

    // Acknowledge on the first WAIT_ACK edge; returns at a negedge in IDLE.
    task automatic do_ack();
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx actual=%b expected=1", tx);
        end
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL idle_no_request cycle=%0d actual=%b expected=1", k, tx);
            end
        end
    endtask

    task automatic test_frame();
        logic [13:0] b;
        for (int n = 0; n < 2; n++) begin
            do_frame(b);
            checks++;
            if (b !== exp_frame(exp_data)) begin
                errors++;
                $display("FAIL frame_%0d actual=%b expected=%b", n, b, exp_frame(exp_data));
            end
            @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL wait_ack_tx actual=%b expected=1", tx);
            end
            rx = 1'b0;
            @(negedge clk);
            rx = 1'b1;
            @(negedge clk);
            exp_data++;
        end
    endtask

    task automatic test_retry();
        logic [13:0] b;
        int g;
        int starts;
        do_frame(b);
        checks++;
        if (b !== exp_frame(exp_data)) begin
            errors++;
            $display("FAIL retry_first actual=%b expected=%b", b, exp_frame(exp_data));
        end
        for (int r = 0; r < 2; r++) begin
            g = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (tx === 1'b0) begin
                    g = k;
                    break;
                end
            end
            checks++;
            if (g != 18) begin
                errors++;
                $display("FAIL retry_gap_%0d actual=%0d expected=18", r, g);
            end
            b[13] = tx;
            for (int i = 12; i >= 0; i--) begin
                @(negedge clk);
                b[i] = tx;
            end
            checks++;
            if (b !== exp_frame(exp_data)) begin
                errors++;
                $display("FAIL retry_frame_%0d actual=%b expected=%b", r, b, exp_frame(exp_data));
            end
        end
        starts = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx === 1'b0) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL retry_dropped low_cycles=%0d expected=0", starts);
        end
        do_frame(b);
        checks++;
        if (b !== exp_frame(exp_data)) begin
            errors++;
            $display("FAIL after_drop actual=%b expected=%b", b, exp_frame(exp_data));
        end
        do_ack();
        exp_data++;
    endtask

    task automatic test_ignore();
        logic [13:0] b;
        int lows;
        rx = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL idle_rx_low actual=%b expected=1", tx);
        end
        data_ready = 1'b1;
        @(negedge clk);
        b[13] = tx;
        for (int i = 12; i >= 0; i--) begin
            data_ready = (i % 2) == 1;
            rx = 1'b0;
            @(negedge clk);
            b[i] = tx;
        end
        rx = 1'b1;
        data_ready = 1'b0;
        checks++;
        if (b !== exp_frame(exp_data)) begin
            errors++;
            $display("FAIL ignore_frame actual=%b expected=%b", b, exp_frame(exp_data));
        end
        do_ack();
        exp_data++;
        lows = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL no_extra_frame low_cycles=%0d expected=0", lows);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] b;
        data_ready = 1'b1;
        @(negedge clk);
        b[13] = tx;
        for (int i = 12; i >= 0; i--) begin
            @(negedge clk);
            b[i] = tx;
        end
        checks++;
        if (b !== exp_frame(exp_data)) begin
            errors++;
            $display("FAIL b2b_first actual=%b expected=%b", b, exp_frame(exp_data));
        end
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        exp_data++;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_tx actual=%b expected=1", tx);
        end
        @(negedge clk);
        data_ready = 1'b0;
        b[13] = tx;
        for (int i = 12; i >= 0; i--) begin
            @(negedge clk);
            b[i] = tx;
        end
        checks++;
        if (b !== exp_frame(exp_data)) begin
            errors++;
            $display("FAIL b2b_second actual=%b expected=%b", b, exp_frame(exp_data));
        end
        do_ack();
        exp_data++;
    endtask

    task automatic test_wrap();
        logic [13:0] b;
        for (int n = 0; n < 256; n++) begin
            do_frame(b);
            checks++;
            if (b !== exp_frame(exp_data)) begin
                errors++;
                $display("FAIL wrap n=%0d actual=%b expected=%b", n, b, exp_frame(exp_data));
            end
            do_ack();
            exp_data++;
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] b;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_tx actual=%b expected=1", tx);
        end
        data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold_tx actual=%b expected=1", tx);
        end
        data_ready = 1'b0;
        rstn = 1'b1;
        exp_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        do_frame(b);
        checks++;
        if (b !== exp_frame(exp_data)) begin
            errors++;
            $display("FAIL reset_restart actual=%b expected=%b", b, exp_frame(exp_data));
        end
        do_ack();
        exp_data++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_retry();
        test_ignore();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
